penalty_box_reader: RTL and testbench

- Read-side buffer of the SDECC penalty box.
- Accepts 72-bit codewords flagged as detected-but-uncorrectable (DUE) from the ECC decode path, together with their fill address, into a small circular buffer.
- Streams each buffered codeword to the recovery engine as fixed-width beats over a valid/ready handshake.
- Frees an entry only after its last beat is accepted.

---
 rtl/penalty_box_reader.sv | 155 +++++++++++++++
 tb/tb_penalty_box_reader.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/penalty_box_reader.sv
`default_nettype none
// ============================================================================
// Module   : penalty_box_reader
// Purpose  : Read-side buffer of the SDECC penalty box. Holds DUE codewords
//            and their fill addresses in a small circular buffer, then
//            streams each codeword out as fixed-width beats, LSB beat first,
//            over a valid/ready handshake. An entry is freed only when its
//            last beat is accepted.
// Ports    : clk, rst_n      - clock, asynchronous active-low reset
//            flush           - synchronous clear of all entries / transfer
//            wr_valid/ready  - codeword push handshake (wr_codeword, wr_addr)
//            rd_valid/ready  - beat handshake (rd_beat, rd_addr, rd_first,
//                              rd_last)
//            occupancy       - valid entries, including the one streaming
// Revision : 1.0 - initial release
// ============================================================================
module penalty_box_reader #(
    parameter int WIDTH      = 72,
    parameter int BEAT_WIDTH = 18,
    parameter int DEPTH      = 4,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic                       wr_valid,
    output logic                       wr_ready,
    input  logic [WIDTH-1:0]           wr_codeword,
    input  logic [ADDR_WIDTH-1:0]      wr_addr,
    output logic                       rd_valid,
    input  logic                       rd_ready,
    output logic [BEAT_WIDTH-1:0]      rd_beat,
    output logic [ADDR_WIDTH-1:0]      rd_addr,
    output logic                       rd_first,
    output logic                       rd_last,
    output logic [$clog2(DEPTH):0]     occupancy
);

    localparam int BEATS = WIDTH / BEAT_WIDTH;
    localparam int IW    = $clog2(DEPTH);
    localparam int PW    = IW + 1;
    localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(BEATS - 1);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t                  state_q, state_d;
    logic [PW-1:0]           wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]           rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]           cnt_q, cnt_d;

    logic [WIDTH-1:0]        mem_cw_q   [DEPTH];
    logic [ADDR_WIDTH-1:0]   mem_addr_q [DEPTH];

    logic [IW-1:0]           w_wr_idx;
    logic [IW-1:0]           w_rd_idx;
    logic                    w_full;
    logic                    w_push;
    logic                    w_pop_last;
    logic                    w_hs;
    logic [BEAT_WIDTH-1:0]   w_beats [BEATS];

    assign w_wr_idx = wr_ptr_q[IW-1:0];
    assign w_rd_idx = rd_ptr_q[IW-1:0];

    // Extra pointer MSB separates "full" (same index, laps differ) from empty.
    assign w_full   = (w_wr_idx == w_rd_idx) && (wr_ptr_q[PW-1] != rd_ptr_q[PW-1]);

    // Full is judged before any pop in the same cycle, so a freed slot is
    // only offered to the writer on the following cycle.
    assign wr_ready   = !w_full && !flush;
    assign w_push     = wr_valid && wr_ready;
    assign w_hs       = rd_valid && rd_ready;
    assign w_pop_last = w_hs && rd_last;

    assign occupancy  = wr_ptr_q - rd_ptr_q;

    // Split the entry under the read pointer into beats, LSB beat first.
    for (genvar b = 0; b < BEATS; b++) begin : g_beat
        assign w_beats[b] = mem_cw_q[w_rd_idx][b*BEAT_WIDTH +: BEAT_WIDTH];
    end

    assign rd_valid = (state_q == SEND);
    assign rd_beat  = w_beats[cnt_q];
    assign rd_addr  = mem_addr_q[w_rd_idx];
    assign rd_first = rd_valid && (cnt_q == '0);
    assign rd_last  = rd_valid && (cnt_q == LAST_CNT);

    // Storage carries no reset; its contents only matter once a pointer
    // marks the slot valid.
    always_ff @(posedge clk) begin
        if (w_push) begin
            mem_cw_q[w_wr_idx]   <= wr_codeword;
            mem_addr_q[w_wr_idx] <= wr_addr;
        end
    end

    always_comb begin
        state_d  = state_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (flush) begin
            state_d  = IDLE;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
        end else begin
            if (w_push) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (w_pop_last) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
                cnt_d    = '0;
            end else if (w_hs) begin
                cnt_d = cnt_q + 1'b1;
            end
            // Decisions use the post-edge pointers: a push into an empty
            // buffer shows rd_valid on the very next cycle, and a last-beat
            // pop with another entry behind it continues without a bubble.
            case (state_q)
                IDLE: begin
                    if (wr_ptr_d != rd_ptr_d) begin
                        state_d = SEND;
                    end
                end
                SEND: begin
                    if (w_pop_last && (wr_ptr_d == rd_ptr_d)) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_penalty_box_reader.sv
`default_nettype none
// ============================================================================
// Module   : tb_penalty_box_reader
// Purpose  : Self-checking bench for penalty_box_reader. A queue of stored
//            entries plus a beat index forms the reference; every cycle the
//            DUT outputs are compared against it.
// Revision : 1.0 - initial release
// ============================================================================
module tb_penalty_box_reader;

    localparam int W     = 72;
    localparam int BW    = 18;
    localparam int D     = 4;
    localparam int AW    = 32;
    localparam int BEATS = W / BW;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              flush = 1'b0;
    logic              wr_valid = 1'b0;
    logic              wr_ready;
    logic [W-1:0]      wr_codeword = '0;
    logic [AW-1:0]     wr_addr = '0;
    logic              rd_valid;
    logic              rd_ready = 1'b0;
    logic [BW-1:0]     rd_beat;
    logic [AW-1:0]     rd_addr;
    logic              rd_first;
    logic              rd_last;
    logic [$clog2(D):0] occupancy;

    penalty_box_reader #(
        .WIDTH      (W),
        .BEAT_WIDTH (BW),
        .DEPTH      (D),
        .ADDR_WIDTH (AW)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush       (flush),
        .wr_valid    (wr_valid),
        .wr_ready    (wr_ready),
        .wr_codeword (wr_codeword),
        .wr_addr     (wr_addr),
        .rd_valid    (rd_valid),
        .rd_ready    (rd_ready),
        .rd_beat     (rd_beat),
        .rd_addr     (rd_addr),
        .rd_first    (rd_first),
        .rd_last     (rd_last),
        .occupancy   (occupancy)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int n_pushed = 0;

    // Reference: queue of {codeword, addr} in arrival order, and the index
    // of the next beat of the head entry.
    logic [W+AW-1:0] q [$];
    int              beat = 0;
    logic            stall_prev = 1'b0;
    logic [BW-1:0]   prev_beat = '0;
    logic [AW-1:0]   prev_addr = '0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        logic         exp_valid;
        logic         exp_wr_ready;
        logic         push;
        logic         pop;
        logic [W-1:0] cw;
        logic [BW-1:0] eb;
        @(negedge clk);
        exp_valid    = (q.size() != 0);
        exp_wr_ready = (q.size() < D) && !flush;
        chk("rd_valid", rd_valid, exp_valid);
        chk("wr_ready", wr_ready, exp_wr_ready);
        chk("occupancy", occupancy, q.size());
        if (exp_valid) begin
            cw = q[0][W+AW-1:AW];
            eb = BW'(cw >> (beat * BW));
            chk("rd_beat", rd_beat, eb);
            chk("rd_addr", rd_addr, q[0][AW-1:0]);
            chk("rd_first", rd_first, beat == 0);
            chk("rd_last", rd_last, beat == BEATS - 1);
            if (stall_prev) begin
                chk("stall_beat", rd_beat, prev_beat);
                chk("stall_addr", rd_addr, prev_addr);
            end
        end else begin
            chk("rd_first_idle", rd_first, 1'b0);
            chk("rd_last_idle", rd_last, 1'b0);
        end
        stall_prev = exp_valid && !rd_ready && !flush;
        prev_beat  = rd_beat;
        prev_addr  = rd_addr;
        push = wr_valid && exp_wr_ready;
        pop  = exp_valid && rd_ready;
        @(posedge clk);
        #1;
        if (flush) begin
            q.delete();
            beat = 0;
        end else begin
            if (pop) begin
                if (beat == BEATS - 1) begin
                    void'(q.pop_front());
                    beat = 0;
                end else begin
                    beat++;
                end
            end
            if (push) begin
                q.push_back({wr_codeword, wr_addr});
                n_pushed++;
            end
        end
    endtask

    task automatic set_push(input logic v);
        wr_valid    = v;
        wr_codeword = {$urandom(), $urandom(), $urandom()};
        wr_addr     = $urandom();
    endtask

    initial begin
        int cyc;

        // Reset state while rst_n is held low.
        #12;
        chk("reset_rd_valid", rd_valid, 1'b0);
        chk("reset_rd_first", rd_first, 1'b0);
        chk("reset_rd_last", rd_last, 1'b0);
        chk("reset_occupancy", occupancy, 0);
        chk("reset_wr_ready", wr_ready, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Single known codeword streamed with rd_ready held high.
        wr_valid    = 1'b1;
        wr_codeword = 72'h12_3456_789A_BCDE_F012;
        wr_addr     = 32'h0000_1000;
        rd_ready    = 1'b1;
        tick();
        wr_valid = 1'b0;
        repeat (6) tick();

        // Fill to full, try a fifth push, then drain one entry.
        rd_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            set_push(1'b1);
            tick();
        end
        wr_valid = 1'b0;
        tick();
        rd_ready = 1'b1;
        set_push(1'b1);
        repeat (4) tick();
        wr_valid = 1'b0;
        tick();
        repeat (14) tick();

        // Two queued entries stream back to back.
        rd_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            set_push(1'b1);
            tick();
        end
        wr_valid = 1'b0;
        rd_ready = 1'b1;
        repeat (9) tick();

        // Random pushes against random back-pressure.
        n_pushed = 0;
        cyc      = 0;
        while (n_pushed < 100 && cyc < 3000) begin
            set_push(1'($urandom_range(0, 1)));
            rd_ready = 1'($urandom_range(0, 1));
            tick();
            cyc++;
        end
        chk("random_push_budget", n_pushed >= 100, 1'b1);
        wr_valid = 1'b0;
        rd_ready = 1'b1;
        cyc      = 0;
        while (q.size() != 0 && cyc < 40) begin
            tick();
            cyc++;
        end
        tick();
        chk("random_drain_occ", occupancy, 0);

        // Flush during beat 2 with three entries queued.
        rd_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            set_push(1'b1);
            tick();
        end
        wr_valid = 1'b0;
        rd_ready = 1'b1;
        repeat (2) tick();
        flush = 1'b1;
        set_push(1'b1);
        tick();
        flush    = 1'b0;
        wr_valid = 1'b0;
        tick();
        chk("flush_occ", occupancy, 0);
        set_push(1'b1);
        tick();
        wr_valid = 1'b0;
        repeat (6) tick();

        // Asynchronous reset in the middle of a transfer.
        rd_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            set_push(1'b1);
            tick();
        end
        wr_valid = 1'b0;
        rd_ready = 1'b1;
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rd_valid", rd_valid, 1'b0);
        chk("async_rd_first", rd_first, 1'b0);
        chk("async_rd_last", rd_last, 1'b0);
        chk("async_occupancy", occupancy, 0);
        q.delete();
        beat       = 0;
        stall_prev = 1'b0;
        @(negedge clk);
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        tick();
        set_push(1'b1);
        tick();
        wr_valid = 1'b0;
        repeat (6) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
